// File: rtl/dm_arb_pkg.sv
// Shared constants for the data-memory arbiter and the bus bridge:
// the DM window, the timer windows, port ids and byte-enable patterns.
package dm_arb_pkg;

  localparam logic [31:0] DM_TOP_ADDR = 32'h0000_2fff;

  localparam logic [31:0] TMR0_LO = 32'h0000_7f00;
  localparam logic [31:0] TMR0_HI = 32'h0000_7f0b;
  localparam logic [31:0] TMR1_LO = 32'h0000_7f10;
  localparam logic [31:0] TMR1_HI = 32'h0000_7f1b;

  localparam bit PORT_C = 1'b0;
  localparam bit PORT_D = 1'b1;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  // Words must sit on a 4-byte boundary, halfwords on a 2-byte boundary.
  function automatic logic misaligned(input logic [1:0] lo, input logic [3:0] be);
    return ((be == BE_WORD) && (lo != 2'b00)) ||
           (((be == BE_HALF_LO) || (be == BE_HALF_HI)) && lo[0]);
  endfunction

endpackage

// File: rtl/dm_arb_check.sv
// Combinational legality/alignment check of one requester's address and byte enables.
module dm_arb_check
  import dm_arb_pkg::*;
#(
  parameter logic [31:0] DM_TOP = DM_TOP_ADDR
) (
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  output logic        legal,
  output logic        err
);

  assign legal = (addr <= DM_TOP);
  assign err   = !legal || misaligned(addr[1:0], be);

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: CPU (port 0) has fixed priority, DMA (port 1) is forced in after
// STARVE_LIMIT waiting cycles. Define DM_ARB_TRACE_EN to print every legal write.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter logic [31:0] DM_TOP       = DM_TOP_ADDR,
  parameter int unsigned AW           = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [31:0]   c_addr,
  input  logic [3:0]    c_be,
  input  logic [31:0]   c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [31:0]   c_rdata,
  output logic          c_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [3:0]    d_be,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [1:0]  req, we, legal, err, gnt;
  logic [31:0] addr_arr  [2];
  logic [3:0]  be_arr    [2];
  logic [31:0] wdata_arr [2];
  logic        force_d, sel;
  logic [7:0]  starve_cnt_reg, starve_cnt_next;
  logic [1:0]  rvalid_reg, rvalid_next, err_reg, err_next, rd_reg, rd_next;

  assign req[PORT_C]       = c_req;
  assign req[PORT_D]       = d_req;
  assign we[PORT_C]        = c_we;
  assign we[PORT_D]        = d_we;
  assign addr_arr[PORT_C]  = c_addr;
  assign addr_arr[PORT_D]  = d_addr;
  assign be_arr[PORT_C]    = c_be;
  assign be_arr[PORT_D]    = d_be;
  assign wdata_arr[PORT_C] = c_wdata;
  assign wdata_arr[PORT_D] = d_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chk
      dm_arb_check #(.DM_TOP(DM_TOP)) u_chk (
        .addr  (addr_arr[gi]),
        .be    (be_arr[gi]),
        .legal (legal[gi]),
        .err   (err[gi])
      );
    end
  endgenerate

  always_comb begin
    force_d   = (starve_cnt_reg == LIMIT);
    gnt       = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;

    if (!reset) begin
      if (req[PORT_D] && (!req[PORT_C] || force_d)) gnt[PORT_D] = 1'b1;
      else if (req[PORT_C])                         gnt[PORT_C] = 1'b1;
    end
    sel = gnt[PORT_D];

    // Erroring requests are still granted but never reach the array.
    if (|gnt) begin
      mem_en    = legal[sel] & ~err[sel];
      mem_we    = legal[sel] & ~err[sel] & we[sel];
      mem_addr  = addr_arr[sel][AW+1:2];
      mem_be    = be_arr[sel];
      mem_wdata = wdata_arr[sel];
    end

    if (!req[PORT_D] || gnt[PORT_D]) starve_cnt_next = '0;
    else if (starve_cnt_reg != LIMIT) starve_cnt_next = starve_cnt_reg + 8'd1;
    else                              starve_cnt_next = starve_cnt_reg;

    rvalid_next = gnt;
    err_next    = gnt & err;
    rd_next     = gnt & ~err & ~we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_reg <= '0;
      rvalid_reg     <= '0;
      err_reg        <= '0;
      rd_reg         <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      rvalid_reg     <= rvalid_next;
      err_reg        <= err_next;
      rd_reg         <= rd_next;
    end
  end

  // Responses are masked while reset is high so a pending one is dropped.
  assign c_gnt    = gnt[PORT_C];
  assign d_gnt    = gnt[PORT_D];
  assign c_rvalid = rvalid_reg[PORT_C] & ~reset;
  assign d_rvalid = rvalid_reg[PORT_D] & ~reset;
  assign c_err    = err_reg[PORT_C] & ~reset;
  assign d_err    = err_reg[PORT_D] & ~reset;
  assign c_rdata  = (rd_reg[PORT_C] && !reset) ? mem_rdata : '0;
  assign d_rdata  = (rd_reg[PORT_D] && !reset) ? mem_rdata : '0;

`ifdef DM_ARB_TRACE_EN
  always_ff @(posedge clk) begin
    if (mem_en && mem_we)
      $display("%0t@%s: *%h <= %h", $time, sel ? "D" : "C", {mem_addr, 2'b00}, mem_wdata);
  end
`else
`endif

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory array (word-addressed, 4096 x 32, byte-enabled) between two requesters: the CPU MEM stage (port 0) and the DMA/debug loader (port 1).
- Fixed priority goes to the CPU, with a starvation counter that forces a DMA grant.
- Memory reads are synchronous with 1-cycle latency. Responses are returned per port with a registered valid pulse.
- Requests outside the DM window are answered with an error response and do not touch the memory.

Parameters:
- STARVE_LIMIT, 8: consecutive cycles of DMA request without grant before DMA is forced to win one cycle (legal 1..255).
- DM_TOP, 32'h00002fff: highest legal byte address; addresses above it produce an error response.
- AW, 12: memory word-address width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- c_req  in  1  CPU request; held until c_gnt
- c_we  in  1  CPU write (1) / read (0)
- c_addr  in  32  CPU byte address
- c_be  in  4  CPU byte enables (writes only)
- c_wdata  in  32  CPU write data, already lane-aligned
- c_gnt  out  1  CPU request accepted this cycle (combinational)
- c_rvalid  out  1  CPU response valid (registered)
- c_rdata  out  32  CPU read data; 0 on write or error
- c_err  out  1  CPU error flag, qualified by c_rvalid
- d_req, d_we, d_addr, d_be, d_wdata  in  1/1/32/4/32  DMA request, same semantics as the CPU port
- d_gnt, d_rvalid, d_rdata, d_err  out  1/1/32/1  DMA response, same semantics as the CPU port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  AW  word address = addr[AW+1:2]
- mem_be  out  4  byte enables
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after mem_en with mem_we = 0

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high. While reset is high and on the first cycle after it, all outputs are 0 and the starvation counter is 0. A response still pending when reset asserts is dropped.
- Arbitration:
  - At most one grant per cycle.
  - The CPU wins whenever c_req = 1, unless force_d = 1; force_d = 1 exactly when starve_cnt == STARVE_LIMIT.
  - The DMA wins if d_req = 1 and either c_req = 0 or force_d = 1.
- Starvation counter:
  - Increments each cycle with d_req = 1 and d_gnt = 0, saturating at STARVE_LIMIT.
  - Clears on d_gnt, and on any cycle with d_req = 0.
- Memory access: the granted request drives the mem_* outputs in the same cycle. mem_en = 1 only if the address is legal (addr <= DM_TOP).
- Responses:
  - The granted port's rvalid pulses exactly one cycle after its grant, and only on that port.
  - rdata = mem_rdata for a legal read; 0 for a write or an error.
  - err = 1 if addr > DM_TOP, or if the request is misaligned. Misaligned means:
    - c_be/d_be = 4'b1111 with addr[1:0] != 0, or
    - be in {0011, 1100} with addr[0] != 0.
  - An erroring request is still granted, but mem_en stays 0, so there is no write side effect.
- Back-to-back traffic: a new grant is allowed every cycle (fully pipelined); reads and writes interleave freely.
- Simultaneous events:
  - A same-cycle CPU write and DMA read with force_d = 1: the DMA is served and the CPU waits one cycle.
  - A response is never blocked, because the requester must accept rvalid unconditionally.
- Ungranted requests: no side effects; the requester keeps its request held until granted.

Optional Feature:
- Macro DM_ARB_TRACE_EN.
- Defined: on every legal write, a simulation-only print in the form "<time>@<port>: *<word byte address> <= <wdata>", where port is C or D.
- Undefined: no print statements are compiled; logic is identical.

Decomposition:
- Shared package dm_arb_pkg holds:
  - the DM_TOP and timer window constants (7f00-7f0b, 7f10-7f1b), shared with the bridge;
  - port id constants PORT_C = 0, PORT_D = 1;
  - the byte-enable pattern constants.
- One natural sub-module, dm_arb_check: combinational legality and alignment checker (addr, be -> legal, err), instantiated once per port.

Test Plan:
- Reset then a CPU read: c_req = 1, addr 0x10, memory word 4 = 0xdeadbeef -> c_gnt in the same cycle; c_rvalid = 1 and c_rdata = 0xdeadbeef the next cycle; d_* outputs stay 0.
- Contention, STARVE_LIMIT = 8: c_req and d_req held high continuously -> CPU granted 8 cycles, DMA on the 9th, counter cleared, CPU resumes; the 9-cycle pattern repeats.
- Errors:
  - CPU write be = 1111 to addr 0x6 -> mem_en = 0; c_rvalid with c_err = 1 next cycle; memory unchanged.
  - DMA read of 0x3000 -> d_err = 1, d_rdata = 0.
- Byte write: CPU be = 0100, wdata 0x00ab0000 to 0x20 over a word holding 0x11223344 -> a readback of 0x20 returns 0x11ab3344.
- Reset during a read: reset asserted the cycle after the grant -> no c_rvalid; after reset, all outputs are 0 and starve_cnt is 0.
